exp_mu_table_reader: RTL and testbench
======================================

// Module: exp_mu_table_reader
// PURPOSE
//  Receiving end of the S0*exp(t*mu) table-generator write stream (data/addr/valid/done).
//  Captures the T = t_max-t_min+1 entries into a local table RAM.
//  After the table is loaded, replays it in ascending t order to the downstream
//  path-pricing datapath through a valid/ready handshake, any number of passes.
//  Sits between the exp-table generator and the per-step risk accumulator.
// PARAMETERS
//  t_min   0    first table index written/read
//  t_max   511  last table index; end of fill and end of each read pass
//  logT    9    address width; 2**logT >= t_max+1
//  DW      18   data width (3 int, 15 frac, passed through unmodified)
// PORTS
//  CLK          in   1     single clock; all logic on posedge
//  RST          in   1     asynchronous, active-high reset
//  iData        in   DW    table entry from generator
//  iAddr        in   logT  table index t for iData
//  iValid       in   1     write strobe; iData/iAddr qualified
//  iDone        in   1     generator finished; one-cycle pulse
//  iReadStart   in   1     request one read pass; sampled only in LOADED
//  iReady       in   1     downstream accepts oData this cycle
//  oData        out  DW    table entry being presented
//  oAddr        out  logT  index t of oData
//  oValid       out  1     oData/oAddr valid
//  oLast        out  1     high with the t_max beat
//  oTableReady  out  1     table complete, no pass in progress (state LOADED)
//  oOverrun     out  1     sticky: write attempted during STREAM
// BEHAVIOUR
//  Reset (async assert, sync release): state EMPTY; all outputs 0; skid buffer empty;
//   RAM contents undefined, never read before a complete fill.
//  States: EMPTY -> FILL -> LOADED -> STREAM -> LOADED.
//   EMPTY:  first iValid writes RAM[iAddr] and enters FILL.
//   FILL:   each iValid writes RAM[iAddr] the same cycle; iDone -> LOADED. iValid and iDone
//           in the same cycle: write lands, then LOADED.
//   LOADED: oTableReady=1. iValid (table regeneration) writes and returns to FILL,
//           oTableReady drops next cycle. iReadStart -> STREAM with read pointer = t_min.
//           iValid and iReadStart together: the write wins, no pass starts.
//   STREAM: read pointer issues RAM reads t_min..t_max; sync RAM with 1-cycle latency
//           feeds a 2-entry skid buffer; the pointer advances only while the skid has room,
//           so no beat is lost or duplicated under any iReady pattern.
//           Transfer = oValid & iReady. oData/oAddr/oLast held stable while oValid & ~iReady.
//           First beat: oValid high 2 cycles after the iReadStart cycle. iReady held high gives
//           one beat per cycle: T beats in T consecutive cycles.
//           When the oLast beat transfers -> LOADED (oValid 0 next cycle unless a new pass).
//           iValid/iDone in STREAM: ignored, RAM untouched, oOverrun set (cleared only by RST).
//           iReadStart in STREAM: ignored.
//  Pointer does not wrap: stops issuing after t_max; no address beyond t_max is read.
//  iAddr outside [t_min,t_max]: write suppressed, no state effect.
//  RST mid-STREAM: outputs 0 immediately (async); table must be refilled.
// STRUCTURE
//  Shared package: DW, logT defaults, state encoding (EMPTY/FILL/LOADED/STREAM).
//  Sub-module exp_table_ram: simple dual-port RAM, 1 write port, 1 sync read port
//   (1-cycle latency, no reset), depth 2**logT x DW.
//  Top: FSM, read pointer, in-flight tag (addr, last), 2-entry skid buffer.
// TESTING
//  Fill t=0..511 with data=t*3, pulse iDone -> oTableReady=1 the next cycle, oOverrun=0.
//  iReadStart, iReady=1 -> oValid 2 cycles later, oAddr 0..511 in 512 consecutive
//   cycles, oData=3*oAddr, oLast only on addr 511, then oTableReady=1.
//  Random iReady (50%) over a pass -> exactly 512 transfers, ascending, no gaps or repeats;
//   oData stable whenever oValid & ~iReady.
//  iValid pulse mid-pass -> oOverrun=1, streamed data unchanged, pass completes normally.
//  RST asserted at beat 100 -> oValid=0 within the reset cycle, state EMPTY; iReadStart with
//   no fill -> no oValid.
//  In LOADED, rewrite addr 5 with 0x3FFFF + iDone, second pass -> beat 5 = 0x3FFFF, others 3*t.

Source files
------------

// File: rtl/exp_mu_table_reader_pkg.sv
// exp_mu_table_reader_pkg: shared defaults and FSM state encoding for the exp(t*mu) table reader.
package exp_mu_table_reader_pkg;
   localparam int DEF_T_MIN = 0;
   localparam int DEF_T_MAX = 511;
   localparam int DEF_LOGT  = 9;
   localparam int DEF_DW    = 18;
   typedef enum logic [1:0] {ST_EMPTY, ST_FILL, ST_LOADED, ST_STREAM} state_t;
endpackage

// File: rtl/exp_mu_table_reader_ram.sv
// exp_table_ram: simple dual-port table RAM, one write port, one registered read port, no reset.
module exp_table_ram #(
   parameter int AW = 9,
   parameter int DW = 18
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);
   logic [DW-1:0] r_mem [2**AW];
   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) o_rdata <= r_mem[i_raddr];
   end
endmodule

// File: rtl/exp_mu_table_reader.sv
// exp_mu_table_reader: captures the generator's table stream, then replays it
// in ascending t order over valid/ready through a 2-entry skid buffer.
module exp_mu_table_reader
   import exp_mu_table_reader_pkg::*;
#(
   parameter int t_min = DEF_T_MIN,
   parameter int t_max = DEF_T_MAX,
   parameter int logT  = DEF_LOGT,
   parameter int DW    = DEF_DW
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [DW-1:0]   iData,
   input  logic [logT-1:0] iAddr,
   input  logic            iValid,
   input  logic            iDone,
   input  logic            iReadStart,
   input  logic            iReady,
   output logic [DW-1:0]   oData,
   output logic [logT-1:0] oAddr,
   output logic            oValid,
   output logic            oLast,
   output logic            oTableReady,
   output logic            oOverrun
);
   state_t          r_state;
   logic [logT-1:0] r_ptr;
   logic            r_ptr_act;
   logic            r_rd_v;
   logic [logT-1:0] r_rd_addr;
   logic            r_rd_last;
   logic [DW-1:0]   r_sk_data [2];
   logic [logT-1:0] r_sk_addr [2];
   logic            r_sk_last [2];
   logic [1:0]      r_cnt;
   logic            r_head;
   logic            r_overrun;
   logic            w_in_rng;
   logic            w_we;
   logic            w_start;
   logic            w_pop;
   logic [2:0]      w_occ;
   logic            w_issue;
   logic [logT-1:0] w_rd_addr;
   logic            w_wr_slot;
   logic [DW-1:0]   w_ram_q;

   assign w_in_rng  = (int'(iAddr) >= t_min) && (int'(iAddr) <= t_max);
   assign w_we      = iValid && w_in_rng && (r_state != ST_STREAM);
   assign w_start   = (r_state == ST_LOADED) && iReadStart && !w_we;
   assign w_pop     = oValid && iReady;
   // Occupancy the skid will reach once the in-flight read lands; a new read is
   // only issued when that still leaves a free slot for it.
   assign w_occ     = {1'b0, r_cnt} + {2'b0, r_rd_v} - {2'b0, w_pop};
   assign w_issue   = w_start || ((r_state == ST_STREAM) && r_ptr_act && (w_occ <= 3'd1));
   assign w_rd_addr = w_start ? logT'(t_min) : r_ptr;
   assign w_wr_slot = r_head ^ r_cnt[0];

   assign oValid      = (r_cnt != 2'd0);
   assign oData       = r_sk_data[r_head];
   assign oAddr       = r_sk_addr[r_head];
   assign oLast       = oValid && r_sk_last[r_head];
   assign oTableReady = (r_state == ST_LOADED);
   assign oOverrun    = r_overrun;

   exp_table_ram #(.AW(logT), .DW(DW)) u_ram (
      .i_clk   (CLK),
      .i_we    (w_we),
      .i_waddr (iAddr),
      .i_wdata (iData),
      .i_re    (w_issue),
      .i_raddr (w_rd_addr),
      .o_rdata (w_ram_q)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state   <= ST_EMPTY;
         r_ptr     <= '0;
         r_ptr_act <= 1'b0;
         r_rd_v    <= 1'b0;
         r_rd_addr <= '0;
         r_rd_last <= 1'b0;
         r_sk_data <= '{default: '0};
         r_sk_addr <= '{default: '0};
         r_sk_last <= '{default: 1'b0};
         r_cnt     <= 2'd0;
         r_head    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         case (r_state)
            ST_EMPTY:  if (w_we) r_state <= ST_FILL;
            ST_FILL:   if (iDone) r_state <= ST_LOADED;
            ST_LOADED: r_state <= w_we ? ST_FILL : (w_start ? ST_STREAM : ST_LOADED);
            default: begin
               if (iValid || iDone) r_overrun <= 1'b1;
               if (w_pop && oLast) r_state <= ST_LOADED;
            end
         endcase
         r_rd_v <= w_issue;
         if (w_issue) begin
            r_rd_addr <= w_rd_addr;
            r_rd_last <= (w_rd_addr == logT'(t_max));
            r_ptr     <= w_rd_addr + 1'b1;
            r_ptr_act <= (w_rd_addr != logT'(t_max));
         end
         if (r_rd_v) begin
            r_sk_data[w_wr_slot] <= w_ram_q;
            r_sk_addr[w_wr_slot] <= r_rd_addr;
            r_sk_last[w_wr_slot] <= r_rd_last;
         end
         if (w_pop) r_head <= ~r_head;
         r_cnt <= r_cnt + {1'b0, r_rd_v} - {1'b0, w_pop};
      end
   end
endmodule

// File: tb/tb_exp_mu_table_reader.sv
// tb_exp_mu_table_reader: randomized self-checking bench; the table contents
// and the expected beat order are tracked in a plain array model.
module tb_exp_mu_table_reader;
   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [17:0] iData = '0;
   logic [8:0]  iAddr = '0;
   logic        iValid = 1'b0;
   logic        iDone = 1'b0;
   logic        iReadStart = 1'b0;
   logic        iReady = 1'b0;
   logic [17:0] oData;
   logic [8:0]  oAddr;
   logic        oValid;
   logic        oLast;
   logic        oTableReady;
   logic        oOverrun;

   int n_cmp = 0;
   int n_err = 0;
   logic [17:0] tbl [512];

   exp_mu_table_reader dut (
      .CLK(CLK), .RST(RST), .iData(iData), .iAddr(iAddr), .iValid(iValid),
      .iDone(iDone), .iReadStart(iReadStart), .iReady(iReady), .oData(oData),
      .oAddr(oAddr), .oValid(oValid), .oLast(oLast), .oTableReady(oTableReady),
      .oOverrun(oOverrun)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic fill();
      for (int t = 0; t < 512; t++) begin
         iValid = 1'b1;
         iAddr  = 9'(t);
         iData  = 18'(3 * t);
         iDone  = (t == 511);
         tbl[t] = 18'(3 * t);
         tick();
      end
      iValid = 1'b0;
      iDone  = 1'b0;
      @(negedge CLK);
      chk("fill_ready", 32'(oTableReady), 1);
   endtask

   task automatic pass(input int pct, input int poke);
      int exp_i = 0;
      int cyc = 0;
      int first = -1;
      logic hold = 1'b0;
      logic [17:0] h_data = '0;
      logic [8:0]  h_addr = '0;
      iReadStart = 1'b1;
      tick();
      iReadStart = 1'b0;
      while (exp_i < 512 && cyc < 5000) begin
         iReady = ($urandom_range(99) < pct);
         iValid = (cyc == poke);
         iAddr  = 9'($urandom_range(511));
         iData  = 18'($urandom);
         @(negedge CLK);
         if (hold) begin
            chk("hold_valid", 32'(oValid), 1);
            chk("hold_data", 32'(oData), 32'(h_data));
            chk("hold_addr", 32'(oAddr), 32'(h_addr));
         end
         if (oValid) begin
            if (first < 0) first = cyc;
            chk("beat_addr", 32'(oAddr), 32'(exp_i));
            chk("beat_data", 32'(oData), 32'(tbl[exp_i]));
            chk("beat_last", 32'(oLast), 32'(exp_i == 511));
            hold   = !iReady;
            h_data = oData;
            h_addr = oAddr;
            if (iReady) exp_i++;
         end else hold = 1'b0;
         tick();
         cyc++;
      end
      iReady = 1'b0;
      iValid = 1'b0;
      chk("pass_beats", 32'(exp_i), 512);
      chk("first_latency", 32'(first), 1);
      if (pct == 100) chk("pass_cycles", 32'(cyc), 513);
      @(negedge CLK);
      chk("end_valid", 32'(oValid), 0);
      chk("end_ready", 32'(oTableReady), 1);
   endtask

   initial begin
      #2;
      chk("rst_async_valid", 32'(oValid), 0);
      repeat (3) @(posedge CLK);
      #1 RST = 1'b0;
      @(negedge CLK);
      chk("rst_valid", 32'(oValid), 0);
      chk("rst_ready", 32'(oTableReady), 0);
      chk("rst_overrun", 32'(oOverrun), 0);
      chk("rst_last", 32'(oLast), 0);
      fill();
      chk("fill_overrun", 32'(oOverrun), 0);
      pass(100, -1);
      pass(50, -1);
      pass(70, 200);
      chk("overrun_set", 32'(oOverrun), 1);
      begin
         int n = 0;
         logic found = 1'b0;
         iReady = 1'b1;
         iReadStart = 1'b1;
         tick();
         iReadStart = 1'b0;
         while (!found && n < 1000) begin
            @(negedge CLK);
            if (oValid && oAddr == 9'd100) found = 1'b1;
            else tick();
            n++;
         end
         chk("rst_found_beat", 32'(found), 1);
         RST = 1'b1;
         #1;
         chk("midrst_valid", 32'(oValid), 0);
         chk("midrst_data", 32'(oData), 0);
         chk("midrst_ready", 32'(oTableReady), 0);
         iReady = 1'b0;
         tick();
         RST = 1'b0;
         @(negedge CLK);
         chk("postrst_overrun", 32'(oOverrun), 0);
         chk("postrst_ready", 32'(oTableReady), 0);
      end
      iReady = 1'b1;
      iReadStart = 1'b1;
      tick();
      iReadStart = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         chk("nofill_valid", 32'(oValid), 0);
         tick();
      end
      iReady = 1'b0;
      fill();
      iValid = 1'b1;
      iAddr = 9'd5;
      iData = 18'h3FFFF;
      iReadStart = 1'b1;
      tbl[5] = 18'h3FFFF;
      tick();
      iValid = 1'b0;
      iReadStart = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         chk("rewrite_ready", 32'(oTableReady), 0);
         chk("rewrite_valid", 32'(oValid), 0);
         tick();
      end
      iDone = 1'b1;
      tick();
      iDone = 1'b0;
      @(negedge CLK);
      chk("rewrite_done", 32'(oTableReady), 1);
      pass(50, -1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
